// File: rtl/sdpram_rd_pkg.sv
// Shared definitions for the SDPRAM block-read stream engine.
`ifndef SDPRAM_RD_PKG_SV
`define SDPRAM_RD_PKG_SV
// Only RAMs with unregistered (1) or registered (2) read data are supported.
`define SDPRAM_RD_LAT_LEGAL(lat) ((lat) == 1 || (lat) == 2)
`endif

package sdpram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sdpram_rd_stream_if.sv
// Valid/ready stream carrying block data with a last-beat marker.
interface sdpram_rd_stream_if #(
  parameter int DWID = 32
);
  logic            valid;
  logic            ready;
  logic [DWID-1:0] data;
  logic            last;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/sdpram_rd_stream_buf.sv
// Small synchronous FIFO holding captured read data plus its last flag.
// Depth need not be a power of two; pointers wrap explicitly.
module rd_stream_buf #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads are ignored when empty; writes are never issued when full
  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_next(wr_ptr);
      if (do_rd) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array, no reset needed: contents are only seen when count != 0
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sdpram_rd_stream.sv
// Block-read engine: issues LEN sequential RAM reads from BASE and returns
// the data as a valid/ready stream. Reads are only issued while there is
// guaranteed room in the output buffer for everything already in flight.
module sdpram_rd_stream
  import sdpram_rd_pkg::*;
#(
  parameter int DWID      = 32,
  parameter int AWID      = 10,
  parameter int LWID      = 11,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AWID-1:0]           base,
  input  logic [LWID-1:0]           len,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      ram_re,
  output logic [AWID-1:0]           ram_raddr,
  input  logic [DWID-1:0]           ram_rdata,
  sdpram_rd_stream_if.master        m
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  if (!(`SDPRAM_RD_LAT_LEGAL(RD_LAT))) begin : g_bad_lat
    $error("sdpram_rd_stream: RD_LAT=%0d is illegal, use 1 or 2", RD_LAT);
  end
  if (BUF_DEPTH < RD_LAT + 1) begin : g_bad_depth
    $error("sdpram_rd_stream: BUF_DEPTH=%0d must be at least RD_LAT+1", BUF_DEPTH);
  end

  rd_state_e       state_q, state_d;
  logic            abort_q, abort_d;
  logic            done_q, done_d;
  logic [AWID-1:0] addr_q;
  logic [LWID-1:0] rem_q;
  logic [RD_LAT:1] vld_pipe;
  logic [RD_LAT:1] lst_pipe;
  logic [2:0]      in_flight;
  logic [CW-1:0]   buf_count;
  logic [DWID:0]   buf_rdata;
  logic            accept, issue, last_issue, credit_ok;
  logic            cap, pop, flush, nonempty, out_last;

  assign accept     = (state_q == ST_IDLE) && start && !abort;
  assign last_issue = (rem_q == LWID'(1));
  assign credit_ok  = (int'(in_flight) + int'(buf_count)) < BUF_DEPTH;
  assign issue      = (state_q == ST_ISSUE) && credit_ok;
  assign flush      = abort && (state_q != ST_IDLE) && !abort_q;
  // Arrivals belonging to an aborted block are dropped
  assign cap        = vld_pipe[RD_LAT] && !abort_q;
  assign nonempty   = (buf_count != '0);
  assign pop        = m.ready && nonempty;
  assign out_last   = nonempty && buf_rdata[DWID];

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ram_re    = issue;
  assign ram_raddr = addr_q;
  assign m.valid   = nonempty;
  assign m.data    = nonempty ? buf_rdata[DWID-1:0] : '0;
  assign m.last    = out_last;

  // Reads issued but not yet captured
  always_comb begin
    in_flight = '0;
    for (int i = 1; i <= RD_LAT; i++) in_flight = in_flight + 3'(vld_pipe[i]);
  end

  // Next-state and done-pulse decode
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (len == '0) done_d  = 1'b1;
          else           state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_DRAIN;
          abort_d = 1'b1;
        end else if (issue && last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort_q) begin
          if (in_flight == '0) begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
            done_d  = 1'b1;
          end
        end else if (abort) begin
          abort_d = 1'b1;
        end else if (pop && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, abort flag, done pulse and address/length counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      if (accept) begin
        addr_q <= base;
        rem_q  <= len;
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
    end
  end

  // Read-latency tracker: valid and last tag ride alongside each read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      lst_pipe[1] <= issue && last_issue;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
      end
    end
  end

  rd_stream_buf #(
    .W     (DWID + 1),
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (cap),
    .wr_data ({lst_pipe[RD_LAT], ram_rdata}),
    .rd_en   (pop),
    .rd_data (buf_rdata),
    .count   (buf_count)
  );

endmodule

// File: tb/tb_sdpram_rd_stream.sv
// Directed bench: two engines (RD_LAT 1 and 2) on behavioural RAMs,
// a block table run by one task, plus hand-written abort/reset sequences.
module tb_sdpram_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, m_ready, sel;
  logic [9:0]  base;
  logic [10:0] len;
  int          tests = 0;
  int          fails = 0;

  logic        busy0, done0, re0, busy1, done1, re1;
  logic [9:0]  raddr0, raddr1;
  logic [31:0] rd0, rd1a, rd1b;

  logic        busy, done, ram_re, m_valid, m_last;
  logic [9:0]  ram_raddr;
  logic [31:0] m_data;

  sdpram_rd_stream_if #(.DWID(32)) s0 ();
  sdpram_rd_stream_if #(.DWID(32)) s1 ();
  assign s0.ready = m_ready;
  assign s1.ready = m_ready;

  function automatic logic [31:0] ram_val(input logic [9:0] a);
    return {16'hA5A5, 6'b0, a};
  endfunction

  sdpram_rd_stream #(.DWID(32), .AWID(10), .LWID(11), .RD_LAT(1), .BUF_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .base(base), .len(len),
    .abort(abort && !sel), .busy(busy0), .done(done0), .ram_re(re0),
    .ram_raddr(raddr0), .ram_rdata(rd0), .m(s0));

  sdpram_rd_stream #(.DWID(32), .AWID(10), .LWID(11), .RD_LAT(2), .BUF_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .base(base), .len(len),
    .abort(abort && sel), .busy(busy1), .done(done1), .ram_re(re1),
    .ram_raddr(raddr1), .ram_rdata(rd1b), .m(s1));

  // RAM read ports: unregistered-output (1 cycle) and registered-output (2 cycles)
  always_ff @(posedge clk) if (re0) rd0 <= ram_val(raddr0);
  always_ff @(posedge clk) begin
    if (re1) rd1a <= ram_val(raddr1);
    rd1b <= rd1a;
  end

  always_comb begin
    if (sel) begin
      busy = busy1; done = done1; ram_re = re1; ram_raddr = raddr1;
      m_valid = s1.valid; m_data = s1.data; m_last = s1.last;
    end else begin
      busy = busy0; done = done0; ram_re = re0; ram_raddr = raddr0;
      m_valid = s0.valid; m_data = s0.data; m_last = s0.last;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          sel;
    logic [9:0]  base;
    logic [10:0] len;
    int          mode;       // 0: ready always, 1: ready 3 on / 3 off
    int          poke;       // cycle at which a stray start is pulsed, -1 none
    int          exp_first;  // cycle of first m_valid (start cycle = 0)
    int          exp_done;   // cycle in which done is high
    logic [31:0] exp_d0;
    logic [31:0] exp_dn;
  } vec_t;

  vec_t vecs[7];

  // Called one cycle edge+1; runs a whole block and checks it
  task automatic run_block(input vec_t v);
    int issued, beats, first_cyc, done_cyc, max_out, busy_err;
    logic busy_at_done;
    logic [31:0] d0, dn;
    issued = 0; beats = 0; first_cyc = -1; done_cyc = -1; max_out = 0; busy_err = 0;
    busy_at_done = 1'b1; d0 = '0; dn = '0;
    sel = v.sel; base = v.base; len = v.len; start = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc == v.poke) begin start = 1'b1; base = 10'h300; len = 11'd9; end
      m_ready = (v.mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
      @(negedge clk);
      if (ram_re) begin
        check("raddr", {22'b0, ram_raddr}, {22'b0, v.base + 10'(issued)});
        issued++;
      end
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (m_valid && m_ready) begin
        check("beat_data", m_data, ram_val(v.base + 10'(beats)));
        check("beat_last", {31'b0, m_last}, {31'b0, beats == int'(v.len) - 1});
        if (beats == 0) d0 = m_data;
        dn = m_data;
        beats++;
      end
      if (issued - beats > max_out) max_out = issued - beats;
      if (done) begin
        done_cyc = cyc;
        busy_at_done = busy;
      end else if (cyc > 0 && busy !== (v.len != 0)) begin
        busy_err++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cyc >= 0) break;
    end
    m_ready = 1'b1;
    check("beats", beats, int'(v.len));
    check("issued", issued, int'(v.len));
    check("first_valid_cycle", first_cyc, v.exp_first);
    check("done_cycle", done_cyc, v.exp_done);
    check("busy_low_at_done", {31'b0, busy_at_done}, 32'd0);
    check("busy_profile", busy_err, 0);
    check("credit_le_depth", {31'b0, max_out <= 4}, 32'd1);
    if (v.len != 0) begin
      check("first_data", d0, v.exp_d0);
      check("last_data", dn, v.exp_dn);
    end
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int bad, dones, vbad, rebad;
    vec_t v;
    vecs[0] = '{1'b0, 10'h010, 11'd8,  0, -1,  3, 11, 32'hA5A50010, 32'hA5A50017};
    vecs[1] = '{1'b1, 10'h010, 11'd8,  0, -1,  4, 12, 32'hA5A50010, 32'hA5A50017};
    vecs[2] = '{1'b1, 10'h100, 11'd20, 1, -1,  4, 44, 32'hA5A50100, 32'hA5A50113};
    vecs[3] = '{1'b0, 10'h3FE, 11'd4,  0, -1,  3,  7, 32'hA5A503FE, 32'hA5A50001};
    vecs[4] = '{1'b1, 10'h3FE, 11'd4,  0, -1,  4,  8, 32'hA5A503FE, 32'hA5A50001};
    vecs[5] = '{1'b0, 10'h020, 11'd0,  0, -1, -1,  1, 32'h0,        32'h0};
    vecs[6] = '{1'b0, 10'h040, 11'd5,  0,  2,  3,  8, 32'hA5A50040, 32'hA5A50044};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1; sel = 1'b0;
    base = '0; len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      check("rst_busy",   {31'b0, busy},    32'd0);
      check("rst_done",   {31'b0, done},    32'd0);
      check("rst_ram_re", {31'b0, ram_re},  32'd0);
      check("rst_raddr",  {22'b0, ram_raddr}, 32'd0);
      check("rst_valid",  {31'b0, m_valid}, 32'd0);
      check("rst_data",   m_data,           32'd0);
      check("rst_last",   {31'b0, m_last},  32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_block(vecs[i]);

    // start together with abort in IDLE: nothing may happen
    sel = 1'b0; base = 10'h070; len = 11'd3; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy || ram_re || done || m_valid) bad++;
      @(posedge clk); #1;
    end
    check("idle_abort_wins", bad, 0);

    // abort on the third beat of a 16-beat RD_LAT=2 block
    sel = 1'b1; base = 10'h080; len = 11'd16; start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    check("abort_beat3_valid", {31'b0, m_valid}, 32'd1);
    check("abort_beat3_data", m_data, 32'hA5A50082);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_valid_low", {31'b0, m_valid}, 32'd0);
    check("abort_re_low", {31'b0, ram_re}, 32'd0);
    dones = 0; vbad = 0; rebad = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done) dones++;
      if (m_valid) vbad++;
      if (ram_re) rebad++;
    end
    check("abort_done_count", dones, 1);
    check("abort_no_valid", vbad, 0);
    check("abort_no_reads", rebad, 0);
    check("abort_idle", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    v = '{1'b1, 10'h200, 11'd3, 0, -1, 4, 7, 32'hA5A50200, 32'hA5A50202};
    run_block(v);

    // reset in the middle of a block
    sel = 1'b0; base = 10'h050; len = 11'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_valid", {31'b0, m_valid}, 32'd1);
    rst_n = 1'b0; #1;
    check("mid_rst_busy",  {31'b0, busy},    32'd0);
    check("mid_rst_valid", {31'b0, m_valid}, 32'd0);
    check("mid_rst_re",    {31'b0, ram_re},  32'd0);
    check("mid_rst_raddr", {22'b0, ram_raddr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = '{1'b0, 10'h060, 11'd2, 0, -1, 3, 5, 32'hA5A50060, 32'hA5A50061};
    run_block(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
